timer_count_ctrl: RTL and testbench

- Counting core and sequencer for the 8-bit timer.
- Consumes the configuration fields decoded from TDR/TCR by the APB register block: start_counter, load, up_down, enable, clk_sel.
- Owns the prescaler, the load/run/pause state machine and the 8-bit counter.
- Returns single-cycle overflow/underflow pulses, which the register block captures into TSR.

---
 rtl/timer_pkg.sv | 35 +++
 rtl/timer_prescaler.sv | 55 +++++
 rtl/timer_count_ctrl.sv | 113 +++++++++++
 tb/tb_timer_count_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer: FSM encoding, prescaler select
// codes, default divisors, TCR bit positions and register addresses.
package timer_pkg;

    // Sequencer states; encoding 2'd3 is unused.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // clk_sel codes
    localparam logic [1:0] CLK_SEL_DIV0 = 2'b00;
    localparam logic [1:0] CLK_SEL_DIV1 = 2'b01;
    localparam logic [1:0] CLK_SEL_DIV2 = 2'b10;
    localparam logic [1:0] CLK_SEL_DIV3 = 2'b11;

    // Default prescaler divisors, one per clk_sel code
    localparam int DFLT_DIV0 = 2;
    localparam int DFLT_DIV1 = 4;
    localparam int DFLT_DIV2 = 8;
    localparam int DFLT_DIV3 = 16;

    // TCR field positions
    localparam int LOAD_BIT   = 7;
    localparam int UPDN_BIT   = 5;
    localparam int EN_BIT     = 4;
    localparam int CLKSEL_LSB = 0;

    // Register addresses decoded by the APB register block
    localparam logic [7:0] TDR = 8'h0;
    localparam logic [7:0] TCR = 8'h1;
    localparam logic [7:0] TSR = 8'h2;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: counts enabled edges 0..DIVn-1 and raises a one-cycle
// terminal-count strobe on the edge where the count wraps.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV0 = DFLT_DIV0,
    parameter int DIV1 = DFLT_DIV1,
    parameter int DIV2 = DFLT_DIV2,
    parameter int DIV3 = DFLT_DIV3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       run_i,
    input  logic [1:0] clk_sel_i,
    output logic       tc_o
);

    logic [3:0] pre_q;
    logic [3:0] pre_d;
    logic [3:0] limit;

    // Terminal value (DIVn-1) for the selected divisor.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        limit = 4'(DIV0 - 1);
        unique case (clk_sel_i)
            CLK_SEL_DIV0: limit = 4'(DIV0 - 1);
            CLK_SEL_DIV1: limit = 4'(DIV1 - 1);
            CLK_SEL_DIV2: limit = 4'(DIV2 - 1);
            CLK_SEL_DIV3: limit = 4'(DIV3 - 1);
            default:      limit = 4'(DIV0 - 1);
        endcase
    end

    // Strobe and next count: clear wins, terminal count wraps to zero.
    always_comb begin
        tc_o  = run_i && !clear_i && (pre_q == limit);
        pre_d = pre_q + 4'd1;
        if (clear_i || !run_i || tc_o) begin
            pre_d = 4'd0;
        end
    end

    // Divisor counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            pre_q <= 4'd0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/timer_count_ctrl.sv
// Timer counting core: load/run/pause sequencer, 8-bit up/down counter and
// registered tick/overflow/underflow pulses. The mode for each edge is taken
// straight from load/enable, so a load asserted in any cycle wins on the
// very next edge and discards a pending update.
module timer_count_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV0  = DFLT_DIV0,
    parameter int DIV1  = DFLT_DIV1,
    parameter int DIV2  = DFLT_DIV2,
    parameter int DIV3  = DFLT_DIV3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] start_counter,
    input  logic             load,
    input  logic             up_down,
    input  logic             enable,
    input  logic [1:0]       clk_sel,
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
    output logic             overflow,
    output logic             underflow,
    output logic [1:0]       state
);

    state_e           state_q;
    state_e           state_d;
    logic [1:0]       sel_q;
    logic [WIDTH-1:0] cnt_q;
    logic             tick_q;
    logic             ovf_q;
    logic             unf_q;

    logic             run;
    logic             sel_chg;
    logic             pre_clear;
    logic             pre_tc;

    // Next state: load beats enable; depends only on inputs, so the unused
    // encoding can never persist beyond one edge.
    always_comb begin
        state_d = ST_IDLE;
        if (load) begin
            state_d = ST_LOAD;
        end else if (enable) begin
            state_d = ST_RUN;
        end
    end

    // Prescaler control: a divisor change while running restarts the period.
    always_comb begin
        run       = (state_d == ST_RUN);
        sel_chg   = (state_q == ST_RUN) && (clk_sel != sel_q);
        pre_clear = !run || sel_chg;
    end

    timer_prescaler #(
        .DIV0 (DIV0),
        .DIV1 (DIV1),
        .DIV2 (DIV2),
        .DIV3 (DIV3)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (pre_clear),
        .run_i     (run),
        .clk_sel_i (clk_sel),
        .tc_o      (pre_tc)
    );

    // Sequencer, counter and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= CLK_SEL_DIV0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= clk_sel;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            unique case (state_d)
                ST_LOAD: cnt_q <= start_counter;
                ST_RUN: begin
                    if (pre_tc) begin
                        tick_q <= 1'b1;
                        if (up_down) begin
                            cnt_q <= cnt_q - WIDTH'(1);
                            unf_q <= (cnt_q == '0);
                        end else begin
                            cnt_q <= cnt_q + WIDTH'(1);
                            ovf_q <= (cnt_q == '1);
                        end
                    end
                end
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign cnt       = cnt_q;
    assign tick      = tick_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_timer_count_ctrl.sv
// Self-checking bench for timer_count_ctrl: directed scenarios followed by
// randomized traffic, all compared against an edge-counting reference model.
module tb_timer_count_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] start_counter;
    logic       load;
    logic       up_down;
    logic       enable;
    logic [1:0] clk_sel;
    logic [7:0] cnt;
    logic       tick;
    logic       overflow;
    logic       underflow;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    // Reference model: counts RUN edges within the current period and
    // updates the value when that count reaches the divisor.
    logic [7:0] m_cnt;
    logic       m_tick, m_ovf, m_unf;
    logic [1:0] m_state;
    int         m_phase;
    logic [1:0] m_prev_sel;
    logic       m_prev_run;

    logic [7:0] snap;

    timer_count_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_counter (start_counter),
        .load          (load),
        .up_down       (up_down),
        .enable        (enable),
        .clk_sel       (clk_sel),
        .cnt           (cnt),
        .tick          (tick),
        .overflow      (overflow),
        .underflow     (underflow),
        .state         (state)
    );

    always #5 clk = ~clk;

    function automatic int div_of(input logic [1:0] s);
        return 2 << s;
    endfunction

    task automatic model_reset();
        m_cnt      = 8'h00;
        m_tick     = 1'b0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        m_state    = 2'd0;
        m_phase    = 0;
        m_prev_sel = 2'b00;
        m_prev_run = 1'b0;
    endtask

    task automatic model_step();
        m_tick = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        if (load) begin
            m_state = 2'd1;
            m_cnt   = start_counter;
            m_phase = 0;
        end else if (enable) begin
            m_state = 2'd2;
            if (m_prev_run && (clk_sel != m_prev_sel)) begin
                m_phase = 0;
            end else begin
                m_phase++;
                if (m_phase == div_of(clk_sel)) begin
                    m_phase = 0;
                    m_tick  = 1'b1;
                    if (up_down) begin
                        m_unf = (m_cnt == 8'h00);
                        m_cnt = m_cnt - 8'd1;
                    end else begin
                        m_ovf = (m_cnt == 8'hFF);
                        m_cnt = m_cnt + 8'd1;
                    end
                end
            end
        end else begin
            m_state = 2'd0;
            m_phase = 0;
        end
        m_prev_run = (m_state == 2'd2);
        m_prev_sel = clk_sel;
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (cnt === m_cnt) else begin
            failures++;
            $error("FAIL %s cnt observed=%h expected=%h", tag, cnt, m_cnt);
        end
        checks++;
        assert (tick === m_tick) else begin
            failures++;
            $error("FAIL %s tick observed=%b expected=%b", tag, tick, m_tick);
        end
        checks++;
        assert (overflow === m_ovf) else begin
            failures++;
            $error("FAIL %s overflow observed=%b expected=%b", tag, overflow, m_ovf);
        end
        checks++;
        assert (underflow === m_unf) else begin
            failures++;
            $error("FAIL %s underflow observed=%b expected=%b", tag, underflow, m_unf);
        end
        checks++;
        assert (state === m_state) else begin
            failures++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, m_state);
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs
    // are compared 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        load          = 1'b1;
        start_counter = 8'h5A;
        up_down       = 1'b0;
        enable        = 1'b0;
        clk_sel       = 2'b00;
        model_reset();

        // Reset state, then release into LOAD
        #2;
        check_all("reset");
        run(2, "in_reset");
        rst_n = 1'b1;
        cycle("load_5a");
        check_val("load_5a_cnt", cnt, 8'h5A);
        cycle("load_5a_hold");

        // Up-count wrap FE->FF->00->01 with divisor 2
        start_counter = 8'hFE;
        cycle("load_fe");
        load   = 1'b0;
        enable = 1'b1;
        run(2, "up_ff");
        check_val("up_ff_cnt", cnt, 8'hFF);
        run(2, "up_00");
        check_val("up_00_cnt", cnt, 8'h00);
        check_val("up_00_ovf", {7'd0, overflow}, 8'h01);
        run(2, "up_01");
        check_val("up_01_cnt", cnt, 8'h01);
        check_val("up_01_ovf", {7'd0, overflow}, 8'h00);

        // Down-count wrap 01->00->FF with divisor 16
        load          = 1'b1;
        start_counter = 8'h01;
        up_down       = 1'b1;
        clk_sel       = 2'b11;
        cycle("load_01");
        load = 1'b0;
        run(16, "dn_00");
        check_val("dn_00_cnt", cnt, 8'h00);
        run(16, "dn_ff");
        check_val("dn_ff_cnt", cnt, 8'hFF);
        check_val("dn_ff_unf", {7'd0, underflow}, 8'h01);
        cycle("dn_after");

        // Pause mid-period with divisor 8, resume gives a full period
        load          = 1'b1;
        start_counter = 8'h20;
        up_down       = 1'b0;
        clk_sel       = 2'b10;
        cycle("load_20");
        load = 1'b0;
        run(6, "pre_run");
        enable = 1'b0;
        snap   = cnt;
        run(5, "pause");
        check_val("pause_hold", cnt, snap);
        enable = 1'b1;
        run(7, "resume_wait");
        check_val("resume_hold", cnt, snap);
        cycle("resume_upd");
        check_val("resume_upd_cnt", cnt, snap + 8'd1);

        // Load one edge before terminal count at FF: no overflow
        load          = 1'b1;
        start_counter = 8'hFF;
        clk_sel       = 2'b00;
        cycle("load_ff");
        load = 1'b0;
        cycle("ff_half");
        load          = 1'b1;
        start_counter = 8'h10;
        cycle("load_wins");
        check_val("load_wins_cnt", cnt, 8'h10);
        check_val("load_wins_ovf", {7'd0, overflow}, 8'h00);

        // Divisor change in RUN restarts a full 16-edge period
        load = 1'b0;
        run(3, "sel0_run");
        clk_sel = 2'b11;
        cycle("sel_chg");
        snap = cnt;
        run(15, "sel3_wait");
        check_val("sel3_hold", cnt, snap);
        cycle("sel3_upd");
        check_val("sel3_upd_cnt", cnt, snap + 8'd1);

        // Asynchronous reset mid-period
        run(5, "pre_rst");
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        run(2, "rst_hold");
        rst_n = 1'b1;
        run(20, "post_rst");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(99) < 3);
            if ($urandom_range(99) < 10) enable = ($urandom_range(99) < 85);
            if ($urandom_range(99) < 5) up_down = ~up_down;
            if ($urandom_range(99) < 3) clk_sel = 2'($urandom_range(3));
            if (load) begin
                case ($urandom_range(2))
                    0:       start_counter = 8'hFF - 8'($urandom_range(3));
                    1:       start_counter = 8'($urandom_range(3));
                    default: start_counter = 8'($urandom);
                endcase
            end
            cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
